pipe_skid_reg: RTL

PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

---
 rtl/pipe_skid_reg_pkg.sv | 29 ++
 rtl/pipe_skid_reg_slot.sv | 18 +
 rtl/pipe_skid_reg.sv | 67 ++++++
 3 files changed

// File: rtl/pipe_skid_reg_pkg.sv
// pipe_skid_reg_pkg: shared MEM/WB payload layout and skid register state encoding.
package pipe_skid_reg_pkg;
  localparam int PC_W  = 32;
  localparam int INS_W = 32;
  localparam int RWA_W = 5;
  localparam int RES_W = 32;
  localparam int DAL_W = 2;
  localparam int TN_W  = 1;
  localparam int RWD_W = 32;
  localparam int MEMWB_W = PC_W + INS_W + RWA_W + RES_W + DAL_W + TN_W + RWD_W;
  typedef struct packed {
    logic [PC_W-1:0]  pc;
    logic [INS_W-1:0] ins;
    logic [RWA_W-1:0] rwa;
    logic [RES_W-1:0] res;
    logic [DAL_W-1:0] dal;
    logic [TN_W-1:0]  tn;
    logic [RWD_W-1:0] rwd;
  } memwb_t;
  // Encoding doubles as the held-entry count.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } skid_state_e;
  function automatic logic [1:0] state_count(input skid_state_e s);
    return 2'(s);
  endfunction
endpackage

// File: rtl/pipe_skid_reg_slot.sv
// pipe_slot: WIDTH-bit payload register with load enable and synchronous clear to BUBBLE.
module pipe_slot
  import pipe_skid_reg_pkg::*;
#(
  parameter int                WIDTH  = MEMWB_W,
  parameter logic [WIDTH-1:0]  BUBBLE = '0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             ld,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] data_d, data_q;
  always_comb data_d = clr ? BUBBLE : ld ? d : data_q;
  always_ff @(posedge clk) data_q <= data_d;
  assign q = data_q;
endmodule

// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: pipeline register with optional two-entry skid buffer and flush.
module pipe_skid_reg
  import pipe_skid_reg_pkg::*;
#(
  parameter int                WIDTH  = MEMWB_W,
  parameter int                SKID   = 1,
  parameter logic [WIDTH-1:0]  BUBBLE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [1:0]       count
);
  skid_state_e      state_d, state_q;
  logic             out_valid_d, out_valid_q;
  logic             in_fire, out_fire;
  logic             main_ld, main_clr, skid_ld, skid_clr;
  logic [WIDTH-1:0] main_in, skid_q;
  assign in_ready = !reset && ((SKID != 0) ? (state_q != ST_TWO) : (out_ready || !out_valid_q));
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid_q && out_ready;
  always_comb begin
    state_d     = flush                  ? ST_EMPTY :
                  state_q == ST_EMPTY    ? (in_fire ? ST_ONE : ST_EMPTY) :
                  state_q == ST_TWO      ? (out_fire ? ST_ONE : ST_TWO) :
                  (in_fire && !out_fire && SKID != 0) ? ST_TWO :
                  (!in_fire && out_fire) ? ST_EMPTY : ST_ONE;
    out_valid_d = state_d != ST_EMPTY;
    // Clearing main on every entry to EMPTY keeps out_data at BUBBLE while idle.
    main_clr    = reset || state_d == ST_EMPTY;
    main_ld     = (state_q == ST_TWO) ? out_fire : in_fire && (state_q == ST_EMPTY || out_fire);
    main_in     = (state_q == ST_TWO) ? skid_q : in_data;
    skid_clr    = reset || flush || (state_q == ST_TWO && out_fire);
    skid_ld     = state_q == ST_ONE && state_d == ST_TWO;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_EMPTY;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
    end
  end
  pipe_slot #(.WIDTH(WIDTH), .BUBBLE(BUBBLE)) u_main (
    .clk (clk),
    .clr (main_clr),
    .ld  (main_ld),
    .d   (main_in),
    .q   (out_data)
  );
  pipe_slot #(.WIDTH(WIDTH), .BUBBLE(BUBBLE)) u_skid (
    .clk (clk),
    .clr (skid_clr),
    .ld  (skid_ld),
    .d   (in_data),
    .q   (skid_q)
  );
  assign out_valid = out_valid_q;
  assign count     = state_count(state_q);
endmodule
